// File: rtl/flasher_pkg.sv
// Shared types and constants for the table-driven bound-flasher sequencer.
// The default table reproduces the classic bound-flasher lamp pattern.
package flasher_pkg;

  localparam int WIDTH = 16;
  localparam int NSEG  = 8;
  localparam int SEG_W = $clog2(NSEG);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int CFG_W = 2 + SEG_W + CNT_W;

  typedef struct packed {
    logic             last;
    logic             kick_en;
    logic [SEG_W-1:0] kick_to;
    logic [CNT_W-1:0] bound;
  } seg_desc_t;

  typedef seg_desc_t [NSEG-1:0] seg_table_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic seg_desc_t mk_seg(input logic             last,
                                       input logic             kick_en,
                                       input logic [SEG_W-1:0] kick_to,
                                       input logic [CNT_W-1:0] bound);
    seg_desc_t s;
    s.last    = last;
    s.kick_en = kick_en;
    s.kick_to = kick_to;
    s.bound   = bound;
    return s;
  endfunction

  // Thermometer code: the lowest n lamps lit.
  function automatic logic [WIDTH-1:0] therm(input logic [CNT_W-1:0] n);
    logic [WIDTH-1:0] t;
    t = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = (CNT_W'(i) < n);
    end
    return t;
  endfunction

  localparam seg_table_t DEFAULT_TABLE = {
    mk_seg(1'b1, 1'b0, 3'd0, 5'd0),   // 7
    mk_seg(1'b1, 1'b0, 3'd0, 5'd0),   // 6
    mk_seg(1'b1, 1'b0, 3'd0, 5'd0),   // 5
    mk_seg(1'b0, 1'b1, 3'd3, 5'd16),  // 4
    mk_seg(1'b0, 1'b1, 3'd2, 5'd5),   // 3
    mk_seg(1'b0, 1'b0, 3'd0, 5'd11),  // 2
    mk_seg(1'b0, 1'b0, 3'd0, 5'd0),   // 1
    mk_seg(1'b0, 1'b0, 3'd0, 5'd6)    // 0
  };

endpackage

// File: rtl/lamp_therm_reg.sv
// Lit-lamp counter driven by inc/dec commands; registers both the count and
// its thermometer lamp image so the lamp output comes straight from a flop.
module lamp_therm_reg
  import flasher_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] n,
  output logic [WIDTH-1:0] lamp
);

  logic [CNT_W-1:0] n_d, n_q;
  logic [WIDTH-1:0] lamp_d, lamp_q;

  // Next count; the controller never asks to step past 0 or WIDTH.
  always_comb begin
    n_d = n_q;
    if (inc) begin
      n_d = n_q + 5'd1;
    end else if (dec) begin
      n_d = n_q - 5'd1;
    end else begin
      n_d = n_q;
    end
    lamp_d = therm(n_d);
  end

  // Count and lamp registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q    <= 5'd0;
      lamp_q <= 16'h0000;
    end else begin
      n_q    <= n_d;
      lamp_q <= lamp_d;
    end
  end

  assign n    = n_q;
  assign lamp = lamp_q;

endmodule

// File: rtl/flasher_seq_ctrl.sv
// Table-driven lamp sequencer: walks the segment table, steering the lit count
// toward each segment's bound and handling flick kickbacks at bound cycles.
module flasher_seq_ctrl
  import flasher_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flick,
  input  logic             cfg_we,
  input  logic [SEG_W-1:0] cfg_idx,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_err,
  output logic [WIDTH-1:0] lamp,
  output logic             busy,
  output logic             done,
  output logic [SEG_W-1:0] seg_idx
);

  state_e           state_d, state_q;
  seg_table_t       table_d, table_q;
  logic [SEG_W-1:0] seg_idx_d, seg_idx_q;
  logic             done_d, done_q;
  logic             cfg_err_d, cfg_err_q;
  logic             busy_d, busy_q;
  logic             inc, dec;
  logic [CNT_W-1:0] n;
  seg_desc_t        cur_seg;
  logic [CNT_W-1:0] bound_eff;

  lamp_therm_reg u_lamp (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .dec   (dec),
    .n     (n),
    .lamp  (lamp)
  );

  // Oversized bounds clamp to WIDTH so the count can never wrap.
  always_comb begin
    cur_seg   = table_q[seg_idx_q];
    bound_eff = (cur_seg.bound > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cur_seg.bound;
  end

  // Next-state, table update and step commands.
  always_comb begin
    state_d   = state_q;
    table_d   = table_q;
    seg_idx_d = seg_idx_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    inc       = 1'b0;
    dec       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          table_d[cfg_idx] = seg_desc_t'(cfg_data);
        end else begin
          table_d = table_q;
        end
        if (flick) begin
          state_d   = ST_RUN;
          seg_idx_d = 3'd0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cfg_we) begin
          cfg_err_d = 1'b1;
        end else begin
          cfg_err_d = 1'b0;
        end
        if (n < bound_eff) begin
          inc = 1'b1;
        end else if (n > bound_eff) begin
          dec = 1'b1;
        end else if (cur_seg.kick_en && flick) begin
          seg_idx_d = cur_seg.kick_to;
        end else if (cur_seg.last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (seg_idx_q == SEG_W'(NSEG - 1)) begin
          seg_idx_d = 3'd0;
        end else begin
          seg_idx_d = seg_idx_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, table and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      table_q   <= DEFAULT_TABLE;
      seg_idx_q <= 3'd0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      table_q   <= table_d;
      seg_idx_q <= seg_idx_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      busy_q    <= busy_d;
    end
  end

  assign seg_idx = seg_idx_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_flasher_seq_ctrl.sv
// Scoreboard bench for flasher_seq_ctrl: per-cycle stimulus and expected
// outputs are queued together, then applied and compared cycle by cycle.
module tb_flasher_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flick = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = 3'd0;
  logic [9:0]  cfg_data = 10'd0;
  logic        cfg_err;
  logic [15:0] lamp;
  logic        busy;
  logic        done;
  logic [2:0]  seg_idx;

  flasher_seq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .flick    (flick),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err),
    .lamp     (lamp),
    .busy     (busy),
    .done     (done),
    .seg_idx  (seg_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lamp;
    logic [2:0]  seg;
    logic        busy;
    logic        done;
    logic        err;
    logic        flick;
    logic        we;
    logic [2:0]  idx;
    logic [9:0]  data;
    bit          is_start;
  } ent_t;

  ent_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;

  int cur_n = 0;
  int cur_seg = 0;
  bit cur_busy = 1'b0;
  bit pend_we = 1'b0;
  logic [2:0] pend_idx = 3'd0;
  logic [9:0] pend_data = 10'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] therm_exp(input int n);
    logic [31:0] t;
    t = (32'd1 << n) - 32'd1;
    return t[15:0];
  endfunction

  task automatic push(input int n, input int seg, input bit b, input bit d, input bit fl, input bit st);
    ent_t e;
    e.lamp = therm_exp(n);
    e.seg = 3'(seg);
    e.busy = b;
    e.done = d;
    e.err = pend_we && cur_busy;
    e.flick = fl;
    e.we = pend_we;
    e.idx = pend_idx;
    e.data = pend_data;
    e.is_start = st;
    q.push_back(e);
    pend_we = 1'b0;
    cur_busy = b;
  endtask

  task automatic wr(input int idx, input bit last, input bit ke, input int kt, input int bnd);
    logic [2:0] kt3;
    logic [4:0] b5;
    kt3 = 3'(kt);
    b5 = 5'(bnd);
    pend_we = 1'b1;
    pend_idx = 3'(idx);
    pend_data = {last, ke, kt3, b5};
  endtask

  task automatic start();
    cur_seg = 0;
    push(cur_n, 0, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic steps(input int target, input bit rfl);
    while (cur_n != target) begin
      cur_n = (cur_n < target) ? cur_n + 1 : cur_n - 1;
      push(cur_n, cur_seg, 1'b1, 1'b0, rfl, 1'b0);
    end
  endtask

  task automatic bound_cyc(input bit bfl, input int nxt, input bit last);
    if (last) begin
      push(cur_n, cur_seg, 1'b0, 1'b1, bfl, 1'b0);
    end else begin
      cur_seg = nxt;
      push(cur_n, cur_seg, 1'b1, 1'b0, bfl, 1'b0);
    end
  endtask

  task automatic ramp_to(input int t, input bit rfl, input bit bfl, input int nxt, input bit last);
    steps(t, rfl);
    bound_cyc(bfl, nxt, last);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) push(cur_n, cur_seg, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic default_program();
    start();
    ramp_to(6, 1'b0, 1'b0, 1, 1'b0);
    ramp_to(0, 1'b0, 1'b0, 2, 1'b0);
    ramp_to(11, 1'b0, 1'b0, 3, 1'b0);
    ramp_to(5, 1'b0, 1'b0, 4, 1'b0);
    ramp_to(16, 1'b0, 1'b0, 5, 1'b0);
    ramp_to(0, 1'b0, 1'b0, 0, 1'b1);
    idle(2);
  endtask

  task automatic run_queue();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      flick = e.flick;
      cfg_we = e.we;
      cfg_idx = e.idx;
      cfg_data = e.data;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (e.is_start) start_cyc = cyc;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      chk($sformatf("lamp@%0d", cyc), 32'(lamp), 32'(e.lamp));
      chk($sformatf("seg_idx@%0d", cyc), 32'(seg_idx), 32'(e.seg));
      chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(e.busy));
      chk($sformatf("done@%0d", cyc), 32'(done), 32'(e.done));
      chk($sformatf("cfg_err@%0d", cyc), 32'(cfg_err), 32'(e.err));
    end
    flick = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_lamp"}, 32'(lamp), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_seg"}, 32'(seg_idx), 32'h0);
    chk({tag, "_err"}, 32'(cfg_err), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur_n = 0;
    cur_seg = 0;
    cur_busy = 1'b0;
  endtask

  initial begin
    // 1: default program end to end.
    do_reset("rst0");
    idle(1);
    done_cnt = 0;
    default_program();
    run_queue();
    chk("t1_cycles", 32'(done_cyc - start_cyc), 32'd62);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);

    // 2: kickback at seg 3 bound, mid-ramp flick ignored.
    start();
    ramp_to(6, 1'b0, 1'b0, 1, 1'b0);
    ramp_to(0, 1'b0, 1'b0, 2, 1'b0);
    ramp_to(11, 1'b0, 1'b0, 3, 1'b0);
    ramp_to(5, 1'b0, 1'b1, 2, 1'b0);
    ramp_to(11, 1'b1, 1'b0, 3, 1'b0);
    ramp_to(5, 1'b1, 1'b0, 4, 1'b0);
    ramp_to(16, 1'b0, 1'b0, 5, 1'b0);
    ramp_to(0, 1'b0, 1'b0, 0, 1'b1);
    idle(1);
    run_queue();

    // 3: single last segment, write and start in the same cycle.
    wr(0, 1'b1, 1'b0, 0, 3);
    start();
    ramp_to(3, 1'b0, 1'b0, 0, 1'b1);
    idle(2);
    // 4: write during RUN dropped; bound 31 clamps at 16.
    wr(0, 1'b0, 1'b0, 0, 8);
    idle(1);
    wr(1, 1'b1, 1'b0, 0, 31);
    idle(1);
    start();
    wr(1, 1'b1, 1'b0, 0, 0);
    ramp_to(8, 1'b0, 1'b0, 1, 1'b0);
    ramp_to(16, 1'b0, 1'b0, 0, 1'b1);
    idle(1);
    // 5: bound equal to n, self-kick holds while flick stays high.
    wr(0, 1'b0, 1'b1, 0, 16);
    idle(1);
    wr(1, 1'b1, 1'b0, 0, 16);
    idle(1);
    start();
    bound_cyc(1'b1, 0, 1'b0);
    bound_cyc(1'b1, 0, 1'b0);
    bound_cyc(1'b0, 1, 1'b0);
    bound_cyc(1'b0, 0, 1'b1);
    idle(1);
    run_queue();

    // 6: async reset mid-ramp, then default program again.
    do_reset("rst1");
    start();
    steps(3, 1'b0);
    run_queue();
    #2;
    reset = 1'b1;
    #1;
    chk("async_lamp", 32'(lamp), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_seg", 32'(seg_idx), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur_n = 0;
    cur_seg = 0;
    cur_busy = 1'b0;
    done_cnt = 0;
    default_program();
    run_queue();
    chk("t6_cycles", 32'(done_cyc - start_cyc), 32'd62);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
